// File: rtl/pcim_arb_pkg.sv
// Shared types and constants for the PCIM read-path arbiter and its helpers.
package pcim_arb_pkg;

  typedef enum logic {
    IDLE,
    ISSUE
  } arb_state_e;

  localparam logic [2:0] PCIM_ARSIZE_64B = 3'b110;
  localparam int         PCIM_ID_W       = 16;

endpackage

// File: rtl/pcim_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] elig,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  int cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!found && elig[IDX_W'(cand)]) begin
        found = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/pcim_rd_arbiter.sv
// Round-robin sharing of the PCIM AR/R channels among NUM_REQ DMA read clients,
// with per-client outstanding-burst credit and rid-based R steering.
module pcim_rd_arbiter
  import pcim_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 512,
  parameter int ID_W    = PCIM_ID_W,
  parameter int MAX_OUT = 4
) (
  input  logic                    clk_main_a0,
  input  logic                    rst_main,
  input  logic [NUM_REQ-1:0]      req_arvalid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_araddr,
  input  logic [NUM_REQ*8-1:0]    req_arlen,
  output logic [NUM_REQ-1:0]      req_arready,
  output logic [NUM_REQ-1:0]      rsp_rvalid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic [1:0]              rsp_rresp,
  output logic                    rsp_rlast,
  input  logic [NUM_REQ-1:0]      rsp_rready,
  output logic                    pcim_arvalid,
  output logic [ADDR_W-1:0]       pcim_araddr,
  output logic [ID_W-1:0]         pcim_arid,
  output logic [7:0]              pcim_arlen,
  output logic [2:0]              pcim_arsize,
  input  logic                    pcim_arready,
  input  logic                    pcim_rvalid,
  input  logic [DATA_W-1:0]       pcim_rdata,
  input  logic [ID_W-1:0]         pcim_rid,
  input  logic [1:0]              pcim_rresp,
  input  logic                    pcim_rlast,
  output logic                    pcim_rready,
  output logic                    rid_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = 4;

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               rid_err_q, rid_err_d;
  logic [CNT_W-1:0]   cnt_q [NUM_REQ];
  logic [CNT_W-1:0]   cnt_d [NUM_REQ];
  logic [IDX_W-1:0]   win_q, win_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [7:0]         len_q, len_d;

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] cnt_inc;
  logic [NUM_REQ-1:0] cnt_dec;
  logic               found;
  logic [IDX_W-1:0]   win_idx;
  logic               grant;
  logic               ar_hs;
  logic               rid_ok;
  logic [IDX_W-1:0]   rid_idx;
  logic               r_hs_last;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_arvalid[i] && (cnt_q[i] < CNT_W'(MAX_OUT));
    end
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .elig  (elig),
    .ptr   (rr_ptr_q),
    .found (found),
    .idx   (win_idx)
  );

  // Grant is masked by reset so req_arready reads 0 while reset is held.
  assign grant     = (state_q == IDLE) && found && !rst_main;
  assign ar_hs     = (state_q == ISSUE) && pcim_arready;
  assign rid_ok    = pcim_rid < ID_W'(NUM_REQ);
  assign rid_idx   = pcim_rid[IDX_W-1:0];
  assign r_hs_last = pcim_rvalid && rid_ok && rsp_rready[rid_idx] && pcim_rlast;

  always_comb begin
    req_arready = '0;
    if (grant) req_arready[win_idx] = 1'b1;
  end

  always_comb begin
    rsp_rvalid = '0;
    if (rid_ok) rsp_rvalid[rid_idx] = pcim_rvalid;
  end

  assign pcim_rready = rid_ok ? rsp_rready[rid_idx] : 1'b1;
  assign rsp_rdata   = pcim_rdata;
  assign rsp_rresp   = pcim_rresp;
  assign rsp_rlast   = pcim_rlast;

  assign pcim_arvalid = (state_q == ISSUE);
  assign pcim_araddr  = addr_q;
  assign pcim_arid    = ID_W'(win_q);
  assign pcim_arlen   = len_q;
  assign pcim_arsize  = PCIM_ARSIZE_64B;
  assign rid_err      = rid_err_q;

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    rid_err_d = rid_err_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d  = ISSUE;
          rr_ptr_d = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
        end
      end
      ISSUE: begin
        if (pcim_arready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (pcim_rvalid && !rid_ok) rid_err_d = 1'b1;
  end

  // Coincident issue and retire on one requester cancel out; retire at zero saturates.
  always_comb begin
    cnt_inc = '0;
    cnt_dec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_inc[i] = ar_hs && (win_q == IDX_W'(i));
      cnt_dec[i] = r_hs_last && (rid_idx == IDX_W'(i));
      cnt_d[i]   = cnt_q[i];
      if (cnt_inc[i] && !cnt_dec[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (cnt_dec[i] && !cnt_inc[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    win_d  = win_q;
    addr_d = addr_q;
    len_d  = len_q;
    if (grant) begin
      win_d  = win_idx;
      addr_d = req_araddr[int'(win_idx)*ADDR_W +: ADDR_W];
      len_d  = req_arlen[int'(win_idx)*8 +: 8];
    end
  end

  always_ff @(posedge clk_main_a0 or posedge rst_main) begin
    if (rst_main) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      rid_err_q <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      rid_err_q <= rid_err_d;
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_ff @(posedge clk_main_a0) begin
    win_q  <= win_d;
    addr_q <= addr_d;
    len_q  <= len_d;
  end

  cnt_underflow_a: assert property (@(posedge clk_main_a0) disable iff (rst_main)
    !(r_hs_last && (cnt_q[rid_idx] == '0) && !(ar_hs && (win_q == rid_idx))));

endmodule

// File: tb/tb_pcim_rd_arbiter.sv
// Directed bench for pcim_rd_arbiter; AR and R traffic checked by queue-based monitors.
module tb_pcim_rd_arbiter;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int IW = 16;
  localparam int MO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    req_arvalid;
  logic [N*AW-1:0] req_araddr;
  logic [N*8-1:0]  req_arlen;
  logic [N-1:0]    req_arready;
  logic [N-1:0]    rsp_rvalid;
  logic [DW-1:0]   rsp_rdata;
  logic [1:0]      rsp_rresp;
  logic            rsp_rlast;
  logic [N-1:0]    rsp_rready;
  logic            pcim_arvalid;
  logic [AW-1:0]   pcim_araddr;
  logic [IW-1:0]   pcim_arid;
  logic [7:0]      pcim_arlen;
  logic [2:0]      pcim_arsize;
  logic            pcim_arready;
  logic            pcim_rvalid;
  logic [DW-1:0]   pcim_rdata;
  logic [IW-1:0]   pcim_rid;
  logic [1:0]      pcim_rresp;
  logic            pcim_rlast;
  logic            pcim_rready;
  logic            rid_err;

  pcim_rd_arbiter #(
    .NUM_REQ (N), .ADDR_W (AW), .DATA_W (DW), .ID_W (IW), .MAX_OUT (MO)
  ) dut (
    .clk_main_a0  (clk),
    .rst_main     (rst),
    .req_arvalid  (req_arvalid),
    .req_araddr   (req_araddr),
    .req_arlen    (req_arlen),
    .req_arready  (req_arready),
    .rsp_rvalid   (rsp_rvalid),
    .rsp_rdata    (rsp_rdata),
    .rsp_rresp    (rsp_rresp),
    .rsp_rlast    (rsp_rlast),
    .rsp_rready   (rsp_rready),
    .pcim_arvalid (pcim_arvalid),
    .pcim_araddr  (pcim_araddr),
    .pcim_arid    (pcim_arid),
    .pcim_arlen   (pcim_arlen),
    .pcim_arsize  (pcim_arsize),
    .pcim_arready (pcim_arready),
    .pcim_rvalid  (pcim_rvalid),
    .pcim_rdata   (pcim_rdata),
    .pcim_rid     (pcim_rid),
    .pcim_rresp   (pcim_rresp),
    .pcim_rlast   (pcim_rlast),
    .pcim_rready  (pcim_rready),
    .rid_err      (rid_err)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [IW-1:0] id;
    logic [7:0]    len;
  } ar_t;

  typedef struct packed {
    logic [N-1:0]  vld;
    logic          rdy;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
  } r_t;

  ar_t ar_q[$];
  r_t  r_q[$];
  int  errors = 0;
  int  checks = 0;

  function automatic logic [AW-1:0] addr_of(input int i);
    return 64'h1000 * (i + 1);
  endfunction

  function automatic logic [7:0] len_of(input int i);
    case (i)
      0:       return 8'd3;
      1:       return 8'd1;
      2:       return 8'd5;
      default: return 8'd7;
    endcase
  endfunction

  function automatic ar_t exp_ar(input int i);
    ar_t e;
    e.addr = addr_of(i);
    e.id   = IW'(i);
    e.len  = len_of(i);
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic r_beat(input int rid, input logic last, input logic [N-1:0] rrdy,
                        input logic [N-1:0] evld, input logic erdy, input logic [DW-1:0] d);
    r_t e;
    e.vld  = evld;
    e.rdy  = erdy;
    e.data = d;
    e.resp = 2'b01;
    e.last = last;
    r_q.push_back(e);
    pcim_rvalid = 1'b1;
    pcim_rid    = IW'(rid);
    pcim_rdata  = d;
    pcim_rresp  = 2'b01;
    pcim_rlast  = last;
    rsp_rready  = rrdy;
    tick();
    pcim_rvalid = 1'b0;
    pcim_rlast  = 1'b0;
    rsp_rready  = '0;
  endtask

  // Monitors sample on the falling edge, half a cycle clear of the active edge.
  always @(negedge clk) begin
    ar_t e;
    r_t  r;
    if (pcim_arvalid && pcim_arready) begin
      if (ar_q.size() == 0) begin
        chk("ar_unexpected", 64'(pcim_arid), 64'hFFFF_FFFF);
      end else begin
        e = ar_q.pop_front();
        chk("ar_addr", pcim_araddr, e.addr);
        chk("ar_id", 64'(pcim_arid), 64'(e.id));
        chk("ar_len", 64'(pcim_arlen), 64'(e.len));
        chk("ar_size", 64'(pcim_arsize), 64'h6);
      end
    end
    if (pcim_rvalid) begin
      if (r_q.size() == 0) begin
        chk("r_unexpected", 64'(rsp_rvalid), 64'hFF);
      end else begin
        r = r_q.pop_front();
        chk("r_vld", 64'(rsp_rvalid), 64'(r.vld));
        chk("r_rdy", 64'(pcim_rready), 64'(r.rdy));
        chk("r_data", rsp_rdata, r.data);
        chk("r_resp", 64'(rsp_rresp), 64'(r.resp));
        chk("r_last", 64'(rsp_rlast), 64'(r.last));
      end
    end
  end

  initial begin
    int n;
    rst          = 1'b1;
    req_arvalid  = '0;
    rsp_rready   = '0;
    pcim_arready = 1'b0;
    pcim_rvalid  = 1'b0;
    pcim_rdata   = '0;
    pcim_rid     = '0;
    pcim_rresp   = '0;
    pcim_rlast   = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_araddr[i*AW +: AW] = addr_of(i);
      req_arlen[i*8 +: 8]    = len_of(i);
    end
    tick();
    tick();
    chk("rst_arvalid", 64'(pcim_arvalid), 64'h0);
    chk("rst_arready", 64'(req_arready), 64'h0);
    chk("rst_rvalid", 64'(rsp_rvalid), 64'h0);
    chk("rst_rid_err", 64'(rid_err), 64'h0);
    rst = 1'b0;
    tick();

    // Single requester: grant same cycle, AR next cycle, four beats back to req0.
    pcim_arready = 1'b1;
    ar_q.push_back(exp_ar(0));
    req_arvalid = 4'b0001;
    #1;
    chk("single_arready", 64'(req_arready), 64'h1);
    tick();
    req_arvalid = '0;
    chk("single_arvalid_t1", 64'(pcim_arvalid), 64'h1);
    chk("single_no_arready_issue", 64'(req_arready), 64'h0);
    tick();
    for (int k = 0; k < 4; k++) begin
      r_beat(0, (k == 3), 4'b0001, 4'b0001, 1'b1, 64'hA0 + 64'(k));
    end

    // Fairness: pointer sits at 1 after the single grant; each client gets MAX_OUT bursts.
    for (int k = 0; k < 4 * MO; k++) ar_q.push_back(exp_ar((k + 1) % N));
    req_arvalid = 4'b1111;
    n = 0;
    while (ar_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("fair_drained", 64'(ar_q.size()), 64'h0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("fair_stop_arvalid", 64'(pcim_arvalid), 64'h0);
      chk("fair_stop_arready", 64'(req_arready), 64'h0);
    end

    // Credit stall on req1, released by one rlast beat.
    req_arvalid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_arready", 64'(req_arready), 64'h0);
    end
    pcim_arready = 1'b0;
    r_beat(1, 1'b1, 4'b0010, 4'b0010, 1'b1, 64'hB1);
    n = 0;
    while (req_arready !== 4'b0010 && n < 2) begin
      tick();
      n++;
    end
    chk("credit_grant", 64'(req_arready), 64'h2);
    ar_q.push_back(exp_ar(1));
    tick();

    // Backpressure on AR, plus an R beat to a client that is not ready.
    req_arvalid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      chk("bp_arvalid", 64'(pcim_arvalid), 64'h1);
      chk("bp_araddr", pcim_araddr, addr_of(1));
      chk("bp_arid", 64'(pcim_arid), 64'h1);
      chk("bp_arlen", 64'(pcim_arlen), 64'(len_of(1)));
      chk("bp_arready", 64'(req_arready), 64'h0);
      tick();
    end
    r_beat(2, 1'b1, 4'b0000, 4'b0100, 1'b0, 64'hC2);
    chk("bp_still_issue", 64'(pcim_arvalid), 64'h1);
    pcim_arready = 1'b1;
    tick();
    pcim_arready = 1'b0;

    // Unknown rid: dropped, sticky error.
    r_beat(7, 1'b1, 4'b0000, 4'b0000, 1'b1, 64'hD7);
    chk("bad_rid_err", 64'(rid_err), 64'h1);
    tick();
    tick();
    chk("bad_rid_sticky", 64'(rid_err), 64'h1);

    // Free req3, let it reach ISSUE, then reset mid-cycle.
    r_beat(3, 1'b1, 4'b1000, 4'b1000, 1'b1, 64'hE3);
    tick();
    chk("pre_rst_issue", 64'(pcim_arvalid), 64'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_arvalid", 64'(pcim_arvalid), 64'h0);
    chk("async_rst_arready", 64'(req_arready), 64'h0);
    chk("async_rst_rid_err", 64'(rid_err), 64'h0);
    tick();
    rst          = 1'b0;
    pcim_arready = 1'b1;
    ar_q.push_back(exp_ar(0));
    #1;
    chk("post_rst_lowest", 64'(req_arready), 64'h1);
    tick();
    tick();
    ar_q.push_back(exp_ar(1));
    chk("post_rst_next", 64'(req_arready), 64'h2);
    tick();
    req_arvalid = '0;
    tick();
    tick();
    chk("ar_queue_empty", 64'(ar_q.size()), 64'h0);
    chk("r_queue_empty", 64'(r_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
